// File: rtl/video_in_pkg.sv
// Shared FSM encoding, pixel defaults and the inside-tile test for the
// cache interpolation stage.
package video_in_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_CALC  = 3'd3,
    ST_OUT   = 3'd4
  } state_e;

  localparam int PIX_W_DEF  = 8;
  localparam int FRAC_W_DEF = 4;

  localparam logic [PIX_W_DEF-1:0] BG_PIXEL = '0;

  // 11-bit compare so that offset+count never wraps.
  function automatic logic in_tile(input logic [10:0] n,
                                   input logic [9:0]  dec,
                                   input logic [9:0]  cnt);
    logic [10:0] lo;
    logic [10:0] hi;
    lo = {1'b0, dec};
    hi = lo + {1'b0, cnt};
    return (n >= lo) && (n < hi);
  endfunction

endpackage

// File: rtl/bilin_lerp.sv
// Combinational two-tap weighted sum a*(2^F-f) + b*f; the result is the
// interpolated value scaled by 2^F.
module bilin_lerp #(
  parameter int A_W    = 8,
  parameter int FRAC_W = 4
) (
  input  logic [A_W-1:0]        a_i,
  input  logic [A_W-1:0]        b_i,
  input  logic [FRAC_W-1:0]     f_i,
  output logic [A_W+FRAC_W-1:0] y_o
);

  localparam int OW = A_W + FRAC_W;
  localparam logic [FRAC_W:0] ONE = {1'b1, {FRAC_W{1'b0}}};

  logic [FRAC_W:0] wa;

  assign wa  = ONE - {1'b0, f_i};
  assign y_o = OW'(a_i) * OW'(wa) + OW'(b_i) * OW'(f_i);

endmodule

// File: rtl/cache_interp.sv
// Reads the neighbours of a sub-pixel coordinate from the tile cache and
// returns one interpolated pixel. VIDEO_IN_BILINEAR_EN selects bilinear
// (4 reads); otherwise nearest-neighbour (1 read, rounded coordinate).
module cache_interp
  import video_in_pkg::*;
#(
  parameter int ADDR_SIZE_W = 5,
  parameter int ADDR_SIZE_H = 5,
  parameter int PIX_W       = PIX_W_DEF,
  parameter int FRAC_W      = FRAC_W_DEF
) (
  input  logic                               p_clk,
  input  logic                               p_resetn,
  input  logic                               cache_rdy,
  input  logic [9:0]                         decalage_w,
  input  logic [9:0]                         decalage_h,
  input  logic [9:0]                         cache_w,
  input  logic [9:0]                         cache_h,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [ADDR_SIZE_W+FRAC_W-1:0]      req_x,
  input  logic [ADDR_SIZE_H+FRAC_W-1:0]      req_y,
  output logic [ADDR_SIZE_W+ADDR_SIZE_H-1:0] ram_addr,
  output logic                               r_e,
  input  logic [PIX_W-1:0]                   ram_data,
  output logic [PIX_W-1:0]                   out_pixel,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               busy
);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_FETCH = ST_FETCH;
  localparam logic [2:0] S_DRAIN = ST_DRAIN;
  localparam logic [2:0] S_CALC  = ST_CALC;
  localparam logic [2:0] S_OUT   = ST_OUT;

`ifdef VIDEO_IN_BILINEAR_EN
  localparam int FETCH_N = 4;
`else
  localparam int FETCH_N = 1;
`endif

  logic [2:0]             state_q, state_d;
  logic [1:0]             k_q, k_d;
  logic                   rd_pend_q, rd_in_q;
  logic [1:0]             rd_k_q;
  logic                   out_valid_q;
  logic [PIX_W-1:0]       out_pixel_q;
  logic [ADDR_SIZE_W:0]   xi_q, xi_d, nx;
  logic [ADDR_SIZE_H:0]   yi_q, yi_d, ny;
  logic [PIX_W-1:0]       samp_q [4];
  logic [PIX_W-1:0]       calc_pix;
  logic [ADDR_SIZE_W-1:0] col;
  logic [ADDR_SIZE_H-1:0] row;
  logic                   accept, fetching, nb_in;

  assign req_ready = p_resetn && cache_rdy && (state_q == S_IDLE);
  assign accept    = req_valid && req_ready;
  assign fetching  = (state_q == S_FETCH);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_pixel = out_pixel_q;

`ifdef VIDEO_IN_BILINEAR_EN
  logic [FRAC_W-1:0] fx_q, fy_q;
  logic [PIX_W+FRAC_W-1:0]   top, bot;
  logic [PIX_W+2*FRAC_W-1:0] mix;
  localparam logic [PIX_W+2*FRAC_W:0] HALF2 = (PIX_W+2*FRAC_W+1)'(1) << (2*FRAC_W-1);

  assign xi_d = {1'b0, req_x[ADDR_SIZE_W+FRAC_W-1:FRAC_W]};
  assign yi_d = {1'b0, req_y[ADDR_SIZE_H+FRAC_W-1:FRAC_W]};

  bilin_lerp #(.A_W(PIX_W), .FRAC_W(FRAC_W)) u_top (
    .a_i(samp_q[0]), .b_i(samp_q[1]), .f_i(fx_q), .y_o(top));
  bilin_lerp #(.A_W(PIX_W), .FRAC_W(FRAC_W)) u_bot (
    .a_i(samp_q[2]), .b_i(samp_q[3]), .f_i(fx_q), .y_o(bot));
  bilin_lerp #(.A_W(PIX_W+FRAC_W), .FRAC_W(FRAC_W)) u_vert (
    .a_i(top), .b_i(bot), .f_i(fy_q), .y_o(mix));

  // Exact result never exceeds the pixel range, so truncation is safe.
  assign calc_pix = PIX_W'(({1'b0, mix} + HALF2) >> (2 * FRAC_W));
`else
  localparam logic [ADDR_SIZE_W+FRAC_W:0] HALF_X = (ADDR_SIZE_W+FRAC_W+1)'(1) << (FRAC_W-1);
  localparam logic [ADDR_SIZE_H+FRAC_W:0] HALF_Y = (ADDR_SIZE_H+FRAC_W+1)'(1) << (FRAC_W-1);

  // Rounding may carry into 2**ADDR_SIZE, which then falls outside the tile.
  assign xi_d = (ADDR_SIZE_W+1)'(({1'b0, req_x} + HALF_X) >> FRAC_W);
  assign yi_d = (ADDR_SIZE_H+1)'(({1'b0, req_y} + HALF_Y) >> FRAC_W);
  assign calc_pix = samp_q[0];
`endif

  // Neighbour k: bit 0 steps x, bit 1 steps y.
  always_comb begin
    nx    = xi_q + (ADDR_SIZE_W+1)'(k_q[0]);
    ny    = yi_q + (ADDR_SIZE_H+1)'(k_q[1]);
    col   = ADDR_SIZE_W'(nx) - ADDR_SIZE_W'(decalage_w);
    row   = ADDR_SIZE_H'(ny) - ADDR_SIZE_H'(decalage_h);
    nb_in = fetching && in_tile(11'(nx), decalage_w, cache_w)
                     && in_tile(11'(ny), decalage_h, cache_h);
  end

  assign r_e      = nb_in;
  assign ram_addr = nb_in ? {row, col} : '0;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE:  if (accept) begin
                 state_d = S_FETCH;
                 k_d     = '0;
               end
      S_FETCH: if (k_q == 2'(FETCH_N - 1)) state_d = S_DRAIN;
               else                        k_d     = k_q + 2'd1;
      S_DRAIN: state_d = S_CALC;
      S_CALC:  state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      rd_pend_q   <= 1'b0;
      rd_in_q     <= 1'b0;
      rd_k_q      <= '0;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      rd_pend_q <= fetching;
      rd_in_q   <= nb_in;
      rd_k_q    <= k_q;
      if (state_q == S_CALC) begin
        out_pixel_q <= calc_pix;
        out_valid_q <= 1'b1;
      end else if (state_q == S_OUT && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // RAM data lands one cycle after its read; outside neighbours take BG.
  always_ff @(posedge p_clk) begin
    if (accept) begin
      xi_q <= xi_d;
      yi_q <= yi_d;
`ifdef VIDEO_IN_BILINEAR_EN
      fx_q <= req_x[FRAC_W-1:0];
      fy_q <= req_y[FRAC_W-1:0];
`endif
    end
    if (rd_pend_q) samp_q[rd_k_q] <= rd_in_q ? ram_data : PIX_W'(BG_PIXEL);
  end

endmodule

// File: tb/tb_cache_interp.sv
// Directed bench for cache_interp; expected values follow the build mode
// selected by VIDEO_IN_BILINEAR_EN.
module tb_cache_interp;

`ifdef VIDEO_IN_BILINEAR_EN
  localparam int LAT = 6;
  localparam int E_FULL = 25, E_INT = 10, E_EDGE = 100, E_CRN_A = 75, E_CRN_B = 50;
  localparam int NRD_INT = 4, NRD_EDGE = 2, NRD_CRN_B = 1;
  localparam logic RE0_EDGE = 1'b0;
`else
  localparam int LAT = 3;
  localparam int E_FULL = 40, E_INT = 10, E_EDGE = 200, E_CRN_A = 100, E_CRN_B = 0;
  localparam int NRD_INT = 1, NRD_EDGE = 1, NRD_CRN_B = 0;
  localparam logic RE0_EDGE = 1'b1;
`endif

  logic       p_clk = 1'b0;
  logic       p_resetn = 1'b0;
  logic       cache_rdy = 1'b1;
  logic [9:0] decalage_w = '0, decalage_h = '0, cache_w = 10'd32, cache_h = 10'd32;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [8:0] req_x = '0, req_y = '0;
  logic [9:0] ram_addr;
  logic       r_e;
  logic [7:0] ram_data = '0;
  logic [7:0] out_pixel;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       busy;

  logic [7:0] mem [1024];

  int tests = 0;
  int fails = 0;
  int lat, nreads;
  bit timed_out;
  logic re0;
  logic [9:0] rd_addr [8];
  logic [7:0] got;
  int exp_rd_int [4] = '{227, 228, 259, 260};

  cache_interp dut (
    .p_clk(p_clk), .p_resetn(p_resetn), .cache_rdy(cache_rdy),
    .decalage_w(decalage_w), .decalage_h(decalage_h),
    .cache_w(cache_w), .cache_h(cache_h),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y),
    .ram_addr(ram_addr), .r_e(r_e), .ram_data(ram_data),
    .out_pixel(out_pixel), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  always #5 p_clk = ~p_clk;

  always @(posedge p_clk) if (r_e) ram_data <= mem[ram_addr];

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic set_tile(input int dw, input int dh, input int cw, input int ch);
    decalage_w = 10'(dw); decalage_h = 10'(dh);
    cache_w = 10'(cw);    cache_h = 10'(ch);
  endtask

  // Drives one request and returns latency, issued reads and the pixel.
  task automatic do_req(input logic [8:0] x, input logic [8:0] y);
    int n;
    @(negedge p_clk);
    req_x = x; req_y = y; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge p_clk); n++; end
    timed_out = (n >= 50);
    @(posedge p_clk);
    @(negedge p_clk);
    req_valid = 1'b0;
    lat = 0; nreads = 0; re0 = r_e;
    while (!out_valid && lat < 40) begin
      if (r_e && nreads < 8) begin rd_addr[nreads] = ram_addr; nreads++; end
      @(negedge p_clk);
      lat++;
    end
    if (lat >= 40) timed_out = 1'b1;
    got = out_pixel;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20) begin @(negedge p_clk); n++; end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge p_clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    tests++; if (out_pixel !== 8'd0) begin fails++; $display("FAIL rst_out_pixel got=%0d exp=0", out_pixel); end
    tests++; if (r_e !== 1'b0) begin fails++; $display("FAIL rst_r_e got=%b exp=0", r_e); end
    tests++; if (ram_addr !== 10'd0) begin fails++; $display("FAIL rst_ram_addr got=%0d exp=0", ram_addr); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got=%b exp=0", busy); end
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
    p_resetn = 1'b1;
    @(negedge p_clk);
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rel_req_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_full_tile();
    set_tile(0, 0, 32, 32);
    do_req(9'd56, 9'd120);
    tests++; if (timed_out) begin fails++; $display("FAIL full_timeout got=1 exp=0"); end
    tests++; if (got !== 8'(E_FULL)) begin fails++; $display("FAIL full_pix got=%0d exp=%0d", got, E_FULL); end
    tests++; if (lat !== LAT) begin fails++; $display("FAIL full_latency got=%0d exp=%0d", lat, LAT); end
    wait_idle();
  endtask

  task automatic test_integer_coord();
    do_req(9'd48, 9'd112);
    tests++; if (got !== 8'(E_INT)) begin fails++; $display("FAIL int_pix got=%0d exp=%0d", got, E_INT); end
    tests++; if (nreads !== NRD_INT) begin fails++; $display("FAIL int_nreads got=%0d exp=%0d", nreads, NRD_INT); end
    for (int i = 0; i < NRD_INT; i++) begin
      tests++;
      if (rd_addr[i] !== 10'(exp_rd_int[i])) begin
        fails++; $display("FAIL int_addr%0d got=%0d exp=%0d", i, rd_addr[i], exp_rd_int[i]);
      end
    end
    wait_idle();
  endtask

  task automatic test_bg_edge();
    set_tile(16, 0, 16, 32);
    do_req(9'd248, 9'd32);
    tests++; if (got !== 8'(E_EDGE)) begin fails++; $display("FAIL edge_pix got=%0d exp=%0d", got, E_EDGE); end
    tests++; if (re0 !== RE0_EDGE) begin fails++; $display("FAIL edge_re0 got=%b exp=%b", re0, RE0_EDGE); end
    tests++; if (nreads !== NRD_EDGE) begin fails++; $display("FAIL edge_nreads got=%0d exp=%0d", nreads, NRD_EDGE); end
    tests++; if (rd_addr[0] !== 10'd64) begin fails++; $display("FAIL edge_addr got=%0d exp=64", rd_addr[0]); end
    wait_idle();
  endtask

  task automatic test_corner();
    set_tile(0, 0, 32, 32);
    do_req(9'd500, 9'd496);
    tests++; if (got !== 8'(E_CRN_A)) begin fails++; $display("FAIL corner_pix got=%0d exp=%0d", got, E_CRN_A); end
    tests++; if (nreads !== 1) begin fails++; $display("FAIL corner_nreads got=%0d exp=1", nreads); end
    tests++; if (rd_addr[0] !== 10'd1023) begin fails++; $display("FAIL corner_addr got=%0d exp=1023", rd_addr[0]); end
    wait_idle();
    do_req(9'd504, 9'd496);
    tests++; if (got !== 8'(E_CRN_B)) begin fails++; $display("FAIL corner_half_pix got=%0d exp=%0d", got, E_CRN_B); end
    tests++; if (nreads !== NRD_CRN_B) begin fails++; $display("FAIL corner_half_nreads got=%0d exp=%0d", nreads, NRD_CRN_B); end
    wait_idle();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    do_req(9'd56, 9'd120);
    req_x = 9'd48; req_y = 9'd112; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge p_clk);
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL hold_valid%0d got=%b exp=1", i, out_valid); end
      tests++; if (out_pixel !== 8'(E_FULL)) begin fails++; $display("FAIL hold_pix%0d got=%0d exp=%0d", i, out_pixel, E_FULL); end
      tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL hold_ready%0d got=%b exp=0", i, req_ready); end
    end
    req_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge p_clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL release_valid got=%b exp=0", out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL release_busy got=%b exp=0", busy); end
    do_req(9'd48, 9'd112);
    tests++; if (got !== 8'(E_INT)) begin fails++; $display("FAIL release_next_pix got=%0d exp=%0d", got, E_INT); end
    wait_idle();
  endtask

  task automatic test_reset_mid_fetch();
    int n;
    @(negedge p_clk);
    req_x = 9'd56; req_y = 9'd120; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge p_clk); n++; end
    @(posedge p_clk);
    @(negedge p_clk);
    req_valid = 1'b0;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL midrst_pre_busy got=%b exp=1", busy); end
    p_resetn = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
    tests++; if (r_e !== 1'b0) begin fails++; $display("FAIL midrst_r_e got=%b exp=0", r_e); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL midrst_ready got=%b exp=0", req_ready); end
    @(negedge p_clk);
    p_resetn = 1'b1;
    do_req(9'd56, 9'd120);
    tests++; if (got !== 8'(E_FULL)) begin fails++; $display("FAIL midrst_after_pix got=%0d exp=%0d", got, E_FULL); end
    tests++; if (lat !== LAT) begin fails++; $display("FAIL midrst_after_lat got=%0d exp=%0d", lat, LAT); end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    do_req(9'd48, 9'd112);
    tests++; if (got !== 8'(E_INT)) begin fails++; $display("FAIL b2b_first got=%0d exp=%0d", got, E_INT); end
    do_req(9'd500, 9'd496);
    tests++; if (got !== 8'(E_CRN_A)) begin fails++; $display("FAIL b2b_second got=%0d exp=%0d", got, E_CRN_A); end
    tests++; if (timed_out) begin fails++; $display("FAIL b2b_timeout got=1 exp=0"); end
    wait_idle();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'hA5;
    mem[227] = 8'd10; mem[228] = 8'd20; mem[259] = 8'd30; mem[260] = 8'd40;
    mem[64] = 8'd200; mem[96] = 8'd50;
    mem[1023] = 8'd100;
    test_reset();
    test_full_tile();
    test_integer_coord();
    test_bg_edge();
    test_corner();
    test_backpressure();
    test_reset_mid_fetch();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
